// File: rtl/host_cmd_pkg.sv
// Shared opcodes, status fields and FSM state encoding for the host command master.
package host_cmd_pkg;

  localparam logic [3:0] OP_PING  = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;
  localparam logic [3:0] OP_RESET = 4'd3;

  localparam logic [3:0] ST_PING  = ~OP_PING;
  localparam logic [3:0] ST_WRITE = ~OP_WRITE;
  localparam logic [3:0] ST_READ  = ~OP_READ;
  localparam logic [3:0] ST_RESET = ~OP_RESET;
  localparam int         STATUS_TMO_BIT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_WR,
    S_WR_WAIT,
    S_WB_RD,
    S_RD_SEND,
    S_RESP
  } state_t;

  // A zero request still moves one word.
  function automatic logic [23:0] word_count(input logic [23:0] n);
    return (n == 24'd0) ? 24'd1 : n;
  endfunction

  function automatic logic [31:0] status_word(input logic [3:0] op, input logic tmo);
    logic [31:0] s;
    s = {28'd0, ~op};
    s[STATUS_TMO_BIT] = tmo;
    return s;
  endfunction

endpackage

// File: rtl/host_cmd_master_if.sv
// Classic single-beat Wishbone bus between the host command master and its slave.
interface host_cmd_master_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/host_cmd_timer.sv
// Ack timeout down-counter: reloads while the bus is idle or acked, flags expiry at terminal count.
module host_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run || clear) cnt <= LOAD;
    else if (cnt != '0)       cnt <= cnt - CW'(1);
  end

  assign expired = run && !clear && (cnt == '0);
endmodule

// File: rtl/host_cmd_master.sv
// Wishbone master executing PING/WRITE/READ/RESET host commands.
// Optional ack timeout enabled by defining HOST_CMD_MASTER_TIMEOUT_EN.
//
// state     | meaning
// S_IDLE    | waiting for a host command or reset
// S_WB_WR   | write transfer on the bus, waiting for ack
// S_WR_WAIT | between write words, waiting for next data word
// S_WB_RD   | read transfer on the bus, waiting for ack
// S_RD_SEND | read word held, waiting for oh_ready
// S_RESP    | final status word held, waiting for oh_ready
module host_cmd_master
  import host_cmd_pkg::*;
#(
  parameter int ADDR_INC       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        master_ready,
  input  logic        ih_ready,
  input  logic        ih_reset,
  input  logic [31:0] in_command,
  input  logic [31:0] in_address,
  input  logic [27:0] in_data_count,
  input  logic [31:0] in_data,
  input  logic        oh_ready,
  output logic        oh_en,
  output logic [31:0] out_status,
  output logic [31:0] out_address,
  output logic [27:0] out_data_count,
  output logic [31:0] out_data,
  host_cmd_master_if.master wb
);
  state_t      state;
  logic [3:0]  op;
  logic [31:0] start_addr;
  logic [23:0] remaining;
  logic        tmo_expired;
  logic        unused_bits;

  assign unused_bits   = ^{in_command[31:4], in_data_count[27:24]};
  assign wb.wbm_sel_o  = 4'hF;

`ifdef HOST_CMD_MASTER_TIMEOUT_EN
  host_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (wb.wbm_cyc_o),
    .clear   (wb.wbm_ack_i),
    .expired (tmo_expired)
  );
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYCLES > 0);
  assign tmo_expired = 1'b0;
`endif

  // Suppressed while ih_reset is high so a discarded response never reaches the host.
  assign oh_en = !rst && !ih_reset && oh_ready && (state == S_RD_SEND || state == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      master_ready   <= 1'b0;
      op             <= '0;
      start_addr     <= '0;
      remaining      <= '0;
      out_status     <= '0;
      out_address    <= '0;
      out_data_count <= '0;
      out_data       <= '0;
      wb.wbm_adr_o   <= '0;
      wb.wbm_dat_o   <= '0;
      wb.wbm_we_o    <= 1'b0;
      wb.wbm_cyc_o   <= 1'b0;
      wb.wbm_stb_o   <= 1'b0;
    end else if (ih_reset) begin
      wb.wbm_cyc_o   <= 1'b0;
      wb.wbm_stb_o   <= 1'b0;
      wb.wbm_we_o    <= 1'b0;
      master_ready   <= 1'b0;
      out_status     <= status_word(OP_RESET, 1'b0);
      out_data_count <= '0;
      out_data       <= '0;
      state          <= S_RESP;
    end else begin
      case (state)
        S_IDLE: begin
          master_ready <= 1'b1;
          if (ih_ready) begin
            master_ready <= 1'b0;
            op           <= in_command[3:0];
            start_addr   <= in_address;
            remaining    <= word_count(in_data_count[23:0]);
            case (in_command[3:0])
              OP_WRITE: begin
                wb.wbm_adr_o <= in_address;
                wb.wbm_dat_o <= in_data;
                wb.wbm_we_o  <= 1'b1;
                wb.wbm_cyc_o <= 1'b1;
                wb.wbm_stb_o <= 1'b1;
                state        <= S_WB_WR;
              end
              OP_READ: begin
                wb.wbm_adr_o <= in_address;
                wb.wbm_we_o  <= 1'b0;
                wb.wbm_cyc_o <= 1'b1;
                wb.wbm_stb_o <= 1'b1;
                state        <= S_WB_RD;
              end
              default: begin
                out_status     <= status_word(in_command[3:0], 1'b0);
                out_address    <= in_address;
                out_data_count <= '0;
                out_data       <= '0;
                state          <= S_RESP;
              end
            endcase
          end
        end
        S_WB_WR: begin
          if (wb.wbm_ack_i) begin
            wb.wbm_cyc_o <= 1'b0;
            wb.wbm_stb_o <= 1'b0;
            wb.wbm_we_o  <= 1'b0;
            remaining    <= remaining - 24'd1;
            if (remaining == 24'd1) begin
              out_status     <= status_word(OP_WRITE, 1'b0);
              out_address    <= start_addr;
              out_data_count <= '0;
              out_data       <= wb.wbm_dat_o;
              state          <= S_RESP;
            end else begin
              master_ready <= 1'b1;
              state        <= S_WR_WAIT;
            end
          end else if (tmo_expired) begin
            wb.wbm_cyc_o   <= 1'b0;
            wb.wbm_stb_o   <= 1'b0;
            wb.wbm_we_o    <= 1'b0;
            out_status     <= status_word(op, 1'b1);
            out_address    <= start_addr;
            out_data_count <= '0;
            out_data       <= wb.wbm_dat_o;
            state          <= S_RESP;
          end
        end
        S_WR_WAIT: begin
          if (ih_ready) begin
            master_ready <= 1'b0;
            wb.wbm_adr_o <= wb.wbm_adr_o + 32'(ADDR_INC);
            wb.wbm_dat_o <= in_data;
            wb.wbm_we_o  <= 1'b1;
            wb.wbm_cyc_o <= 1'b1;
            wb.wbm_stb_o <= 1'b1;
            state        <= S_WB_WR;
          end
        end
        S_WB_RD: begin
          if (wb.wbm_ack_i) begin
            wb.wbm_cyc_o   <= 1'b0;
            wb.wbm_stb_o   <= 1'b0;
            remaining      <= remaining - 24'd1;
            out_status     <= status_word(OP_READ, 1'b0);
            out_address    <= start_addr;
            out_data_count <= {4'd0, remaining - 24'd1};
            out_data       <= wb.wbm_dat_i;
            state          <= S_RD_SEND;
          end else if (tmo_expired) begin
            wb.wbm_cyc_o   <= 1'b0;
            wb.wbm_stb_o   <= 1'b0;
            out_status     <= status_word(op, 1'b1);
            out_address    <= start_addr;
            out_data_count <= '0;
            out_data       <= '0;
            state          <= S_RESP;
          end
        end
        S_RD_SEND: begin
          if (oh_ready) begin
            if (remaining == 24'd0) begin
              master_ready <= 1'b1;
              state        <= S_IDLE;
            end else begin
              wb.wbm_adr_o <= wb.wbm_adr_o + 32'(ADDR_INC);
              wb.wbm_cyc_o <= 1'b1;
              wb.wbm_stb_o <= 1'b1;
              state        <= S_WB_RD;
            end
          end
        end
        S_RESP: begin
          if (oh_ready) begin
            master_ready <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_host_cmd_master.sv
// Scoreboard bench for host_cmd_master: Wishbone slave model plus response monitor.
module tb_host_cmd_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        master_ready;
  logic        ih_ready, ih_reset;
  logic [31:0] in_command, in_address, in_data;
  logic [27:0] in_data_count;
  logic        oh_ready, oh_en;
  logic [31:0] out_status, out_address, out_data;
  logic [27:0] out_data_count;

  host_cmd_master_if wb_bus ();

  host_cmd_master #(.ADDR_INC(1), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .master_ready(master_ready),
    .ih_ready(ih_ready), .ih_reset(ih_reset), .in_command(in_command),
    .in_address(in_address), .in_data_count(in_data_count), .in_data(in_data),
    .oh_ready(oh_ready), .oh_en(oh_en), .out_status(out_status),
    .out_address(out_address), .out_data_count(out_data_count), .out_data(out_data),
    .wb(wb_bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] status;
    logic        chk_addr;
    logic [31:0] addr;
    logic [27:0] count;
    logic [31:0] data;
  } resp_t;
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  resp_t       exp_resp[$];
  bus_t        exp_bus[$];
  logic [31:0] rd_data[$];
  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  bit ack_en = 1'b1;
  int wait_cnt = 0;
  bit prev_oh_en = 1'b0;

  // Wishbone slave: acks after ack_delay idle strobe cycles, checks each transfer.
  always @(negedge clk) begin
    if (wb_bus.wbm_ack_i) begin
      wb_bus.wbm_ack_i = 1'b0;
      wait_cnt = 0;
    end else if (wb_bus.wbm_cyc_o && wb_bus.wbm_stb_o && ack_en) begin
      if (wait_cnt >= ack_delay) begin
        bus_t e;
        wb_bus.wbm_ack_i = 1'b1;
        wb_bus.wbm_dat_i = (rd_data.size() > 0) && !wb_bus.wbm_we_o ? rd_data.pop_front() : 32'h0;
        checks++;
        if (exp_bus.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: adr=%h we=%b, none required", wb_bus.wbm_adr_o, wb_bus.wbm_we_o);
        end else begin
          e = exp_bus.pop_front();
          if (wb_bus.wbm_we_o !== e.we || wb_bus.wbm_adr_o !== e.adr ||
              (e.we && wb_bus.wbm_dat_o !== e.dat) || wb_bus.wbm_sel_o !== 4'hF) begin
            errors++;
            $display("FAIL bus_xfer: got we=%b adr=%h dat=%h sel=%h, required we=%b adr=%h dat=%h sel=f",
                     wb_bus.wbm_we_o, wb_bus.wbm_adr_o, wb_bus.wbm_dat_o, wb_bus.wbm_sel_o,
                     e.we, e.adr, e.dat);
          end
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && oh_en) begin
      resp_t e;
      checks++;
      if (!oh_ready || prev_oh_en) begin
        errors++;
        $display("FAIL oh_en_rule: oh_en=1 with oh_ready=%b prev_oh_en=%b, required oh_ready=1 prev=0",
                 oh_ready, prev_oh_en);
      end
      checks++;
      if (exp_resp.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: status=%h count=%0d data=%h, none required",
                 out_status, out_data_count, out_data);
      end else begin
        e = exp_resp.pop_front();
        if (out_status !== e.status || out_data_count !== e.count || out_data !== e.data ||
            (e.chk_addr && out_address !== e.addr)) begin
          errors++;
          $display("FAIL resp: got status=%h addr=%h count=%0d data=%h, required status=%h addr=%h count=%0d data=%h",
                   out_status, out_address, out_data_count, out_data, e.status, e.addr, e.count, e.data);
        end
      end
    end
    prev_oh_en = oh_en;
  end

  function automatic resp_t mk_resp(logic [31:0] st, logic ca, logic [31:0] a, logic [27:0] c, logic [31:0] d);
    resp_t r;
    r.status = st; r.chk_addr = ca; r.addr = a; r.count = c; r.data = d;
    return r;
  endfunction

  function automatic bus_t mk_bus(logic we, logic [31:0] a, logic [31:0] d);
    bus_t b;
    b.we = we; b.adr = a; b.dat = d;
    return b;
  endfunction

  task automatic wait_master_ready(string name);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (master_ready) return;
    end
    checks++; errors++;
    $display("FAIL %s: master_ready stayed 0, required 1", name);
  endtask

  task automatic send_cmd(logic [3:0] op, logic [31:0] addr, logic [27:0] cnt, logic [31:0] data);
    wait_master_ready("cmd_ready");
    @(posedge clk); #1;
    ih_ready = 1'b1; in_command = {28'd0, op}; in_address = addr;
    in_data_count = cnt; in_data = data;
    @(posedge clk); #1;
    ih_ready = 1'b0;
  endtask

  task automatic send_data(logic [31:0] data);
    wait_master_ready("data_ready");
    @(posedge clk); #1;
    ih_ready = 1'b1; in_data = data;
    @(posedge clk); #1;
    ih_ready = 1'b0;
  endtask

  task automatic wait_done(string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_resp.size() == 0 && exp_bus.size() == 0 && master_ready) begin
        @(negedge clk);
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s: timed out, resp pending=%0d bus pending=%0d, required 0", name,
             exp_resp.size(), exp_bus.size());
    exp_resp.delete(); exp_bus.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (master_ready !== 1'b0 || oh_en !== 1'b0 || wb_bus.wbm_cyc_o !== 1'b0 ||
        wb_bus.wbm_stb_o !== 1'b0 || wb_bus.wbm_we_o !== 1'b0 || wb_bus.wbm_sel_o !== 4'hF ||
        wb_bus.wbm_adr_o !== 32'h0 || wb_bus.wbm_dat_o !== 32'h0 || out_status !== 32'h0 ||
        out_data !== 32'h0 || out_address !== 32'h0 || out_data_count !== 28'h0) begin
      errors++;
      $display("FAIL reset_values: mr=%b oh_en=%b cyc=%b stb=%b we=%b sel=%h st=%h, required all 0 and sel=f",
               master_ready, oh_en, wb_bus.wbm_cyc_o, wb_bus.wbm_stb_o, wb_bus.wbm_we_o,
               wb_bus.wbm_sel_o, out_status);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (master_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mr_release: got %b, required 0", master_ready);
    end
    @(negedge clk);
    checks++;
    if (master_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mr_rise: got %b, required 1", master_ready);
    end
  endtask

  task automatic test_ping();
    exp_resp.push_back(mk_resp(32'h0000000F, 1'b0, 32'h0, 28'd0, 32'h0));
    send_cmd(4'd0, 32'h1234, 28'd0, 32'h0);
    wait_done("ping");
  endtask

  task automatic test_illegal_op();
    exp_resp.push_back(mk_resp(32'h0000000A, 1'b0, 32'h0, 28'd0, 32'h0));
    send_cmd(4'd5, 32'h0, 28'd1, 32'h0);
    wait_done("illegal_op");
  endtask

  task automatic test_write();
    ack_delay = 2;
    exp_bus.push_back(mk_bus(1'b1, 32'h100, 32'hA));
    exp_bus.push_back(mk_bus(1'b1, 32'h101, 32'hB));
    exp_bus.push_back(mk_bus(1'b1, 32'h102, 32'hC));
    exp_resp.push_back(mk_resp(32'h0000000E, 1'b0, 32'h0, 28'd0, 32'hC));
    send_cmd(4'd1, 32'h100, 28'd3, 32'hA);
    send_data(32'hB);
    send_data(32'hC);
    wait_done("write");
    ack_delay = 0;
  endtask

  task automatic test_write_wrap();
    exp_bus.push_back(mk_bus(1'b1, 32'hFFFFFFFF, 32'hDEAD0001));
    exp_bus.push_back(mk_bus(1'b1, 32'h00000000, 32'hDEAD0002));
    exp_resp.push_back(mk_resp(32'h0000000E, 1'b0, 32'h0, 28'd0, 32'hDEAD0002));
    send_cmd(4'd1, 32'hFFFFFFFF, 28'd2, 32'hDEAD0001);
    send_data(32'hDEAD0002);
    wait_done("write_wrap");
  endtask

  task automatic test_read();
    ack_delay = 1;
    rd_data.push_back(32'h11111111);
    rd_data.push_back(32'h22222222);
    exp_bus.push_back(mk_bus(1'b0, 32'h20, 32'h0));
    exp_bus.push_back(mk_bus(1'b0, 32'h21, 32'h0));
    exp_resp.push_back(mk_resp(32'h0000000D, 1'b1, 32'h20, 28'd1, 32'h11111111));
    exp_resp.push_back(mk_resp(32'h0000000D, 1'b1, 32'h20, 28'd0, 32'h22222222));
    oh_ready = 1'b0;
    send_cmd(4'd2, 32'h20, 28'd2, 32'h0);
    repeat (10) @(posedge clk);
    #1 oh_ready = 1'b1;
    wait_done("read");
    ack_delay = 0;
  endtask

  task automatic test_read_count0();
    rd_data.push_back(32'h5A5A5A5A);
    exp_bus.push_back(mk_bus(1'b0, 32'h40, 32'h0));
    exp_resp.push_back(mk_resp(32'h0000000D, 1'b1, 32'h40, 28'd0, 32'h5A5A5A5A));
    send_cmd(4'd2, 32'h40, 28'h1000000, 32'h0);
    wait_done("read_count0");
  endtask

  task automatic test_reset_cmd_priority();
    exp_resp.push_back(mk_resp(32'h0000000C, 1'b0, 32'h0, 28'd0, 32'h0));
    wait_master_ready("prio_ready");
    @(posedge clk); #1;
    ih_ready = 1'b1; ih_reset = 1'b1; in_command = 32'h0;
    @(posedge clk); #1;
    ih_ready = 1'b0; ih_reset = 1'b0;
    wait_done("reset_priority");
  endtask

  task automatic test_reset_mid_write();
    exp_bus.push_back(mk_bus(1'b1, 32'h200, 32'h77));
    exp_resp.push_back(mk_resp(32'h0000000C, 1'b0, 32'h0, 28'd0, 32'h0));
    send_cmd(4'd1, 32'h200, 28'd3, 32'h77);
    wait_master_ready("wr_wait");
    @(posedge clk); #1 ih_reset = 1'b1;
    @(posedge clk); #1 ih_reset = 1'b0;
    wait_done("reset_wr_wait");
    checks++;
    if (master_ready !== 1'b1) begin
      errors++; $display("FAIL reset_wr_wait_mr: got %b, required 1", master_ready);
    end
    // Now reset while the bus cycle is open.
    ack_en = 1'b0;
    exp_resp.push_back(mk_resp(32'h0000000C, 1'b0, 32'h0, 28'd0, 32'h0));
    send_cmd(4'd1, 32'h300, 28'd1, 32'h55);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = wb_bus.wbm_cyc_o;
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL reset_cyc_open: cyc never rose, required 1");
      end
    end
    @(posedge clk); #1 ih_reset = 1'b1;
    @(posedge clk); #1 ih_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_bus.wbm_cyc_o !== 1'b0 || wb_bus.wbm_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_cyc_drop: cyc=%b stb=%b, required 0 0", wb_bus.wbm_cyc_o, wb_bus.wbm_stb_o);
    end
    ack_en = 1'b1;
    wait_done("reset_cyc");
    checks++;
    if (master_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cyc_mr: got %b, required 1", master_ready);
    end
  endtask

`ifdef HOST_CMD_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0;
    ack_en = 1'b0;
    exp_resp.push_back(mk_resp(32'h0000001D, 1'b0, 32'h0, 28'd0, 32'h0));
    send_cmd(4'd2, 32'h80, 28'd2, 32'h0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wb_bus.wbm_cyc_o) hi++;
      else if (hi > 0) break;
    end
    checks++;
    if (hi != 8) begin
      errors++; $display("FAIL timeout_len: cyc high %0d cycles, required 8", hi);
    end
    wait_done("timeout");
    ack_en = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1; ih_ready = 1'b0; ih_reset = 1'b0; in_command = '0; in_address = '0;
    in_data_count = '0; in_data = '0; oh_ready = 1'b1;
    wb_bus.wbm_ack_i = 1'b0; wb_bus.wbm_dat_i = '0;
    test_reset();
    test_ping();
    test_illegal_op();
    test_write();
    test_write_wrap();
    test_read();
    test_read_count0();
    test_reset_cmd_priority();
    test_reset_mid_write();
`ifdef HOST_CMD_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(posedge clk);
    checks++;
    if (exp_resp.size() != 0 || exp_bus.size() != 0) begin
      errors++;
      $display("FAIL leftovers: resp=%0d bus=%0d, required 0 0", exp_resp.size(), exp_bus.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/host_cmd_master.md
Name: host_cmd_master

Overview:
- Wishbone master that executes host commands (PING / WRITE / READ / RESET) decoded by the FT245 host interface.
- Sits directly downstream of that interface: it consumes its ih_* command/address/data words and returns responses on its oh_* output port.
- Single clock domain; the Wishbone bus is classic single-beat, one transfer per data word.

Parameters:
ADDR_INC, 1, address increment applied between successive data words of a burst command
TIMEOUT_CYCLES, 1024, ack wait limit in clk cycles; used only with HOST_CMD_MASTER_TIMEOUT_EN

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
master_ready  out  1  block can accept an ih_ready pulse
ih_ready  in  1  one-cycle pulse: in_command/in_address/in_data valid
ih_reset  in  1  one-cycle pulse: host RESET command
in_command  in  32  command; [3:0] = opcode
in_address  in  32  start address
in_data_count  in  28  requested word count; [23:0] used
in_data  in  32  write data word
oh_ready  in  1  host interface can take a response word
oh_en  out  1  one-cycle pulse: out_* valid
out_status  out  32  response status
out_address  out  32  response address
out_data_count  out  28  words remaining after the current one
out_data  out  32  response data word
wbm_adr_o  out  32  Wishbone address
wbm_dat_o  out  32  Wishbone write data
wbm_dat_i  in  32  Wishbone read data
wbm_we_o  out  1  Wishbone write enable
wbm_sel_o  out  4  byte select; constant 4'hF
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Interface: one clock, clk; reset synchronous active-high, rst.
- Reset values:
  - All outputs 0, except wbm_sel_o = 4'hF.
  - State = IDLE; master_ready rises the cycle after rst deasserts.
- Opcodes: PING=0, WRITE=1, READ=2, RESET=3.
- Status encoding:
  - out_status[3:0] = ~opcode, giving PING F, WRITE E, READ D, RESET C.
  - [4] = timeout error; [31:5] = 0.
- Word count: remaining = (in_data_count[23:0]==0) ? 1 : in_data_count[23:0]; 24-bit, decremented once per completed Wishbone transfer.
- master_ready is 1 only in IDLE and WR_WAIT; it drops the cycle after the ih_ready pulse is accepted.
- States:
  - IDLE:
    - ih_reset → RESP(C).
    - ih_ready → latch command, address and remaining.
    - PING → RESP(F).
    - WRITE → WB_WR with in_data.
    - READ → WB_RD.
    - Other opcode → RESP(~opcode), no bus cycle.
  - WB_WR: cyc=stb=we=1, adr/dat driven. On ack: cyc=stb=0 next cycle; remaining--. If remaining becomes 0 → RESP(E), else → WR_WAIT.
  - WR_WAIT: on ih_ready: adr += ADDR_INC, dat = in_data → WB_WR.
  - WB_RD: cyc=stb=1, we=0. On ack: out_data = wbm_dat_i, remaining-- → RD_SEND.
  - RD_SEND:
    - When oh_ready=1, pulse oh_en with status D, out_address = start address, out_data_count = remaining.
    - Then, if remaining=0 → IDLE, else adr += ADDR_INC → WB_RD.
  - RESP: when oh_ready=1, pulse oh_en, out_data_count = 0, out_data = last write data (0 for PING/RESET) → IDLE.
- oh_en is asserted only in a cycle where oh_ready=1; never in two consecutive cycles.
- Address arithmetic is 32-bit modulo (wraps at FFFFFFFF).
- ih_reset overrides ih_ready when both are asserted in the same cycle.
- ih_reset in any state: cyc/stb drop the next cycle, any pending response is discarded → RESP(C).
- Bus latency: cyc/stb assert the cycle after entry to WB_WR/WB_RD; an ack in the same cycle stb asserts is honoured.

Optional Feature:
- HOST_CMD_MASTER_TIMEOUT_EN defined:
  - Counter runs while cyc=1 and clears on ack.
  - At TIMEOUT_CYCLES without ack: drop cyc/stb, set status[4], abandon remaining words → RESP(~opcode | 0x10); out_data = 0 for reads.
- Undefined: no counter; waits for ack indefinitely.

Decomposition:
- Package host_cmd_pkg: opcode constants, status nibbles, timeout bit index, state encoding.
- Sub-module host_cmd_timer (ack timeout counter), instantiated only under the macro.

Test Plan:
- PING (cmd 0) → no bus cycle; one oh_en with out_status=0000000F, out_data_count=0.
- WRITE, addr 0x100, count 3, data A/B/C, ack after 2 cycles → bus writes A@100, B@101, C@102; then one oh_en with status E.
- READ, addr 0x20, count 2, slave returns 11111111 / 22222222 → two oh_en pulses: data 11111111 with count 1, then data 22222222 with count 0, both status D.
- READ with count 0 → exactly one bus read and one oh_en with out_data_count=0.
- ih_reset mid-WRITE while WR_WAIT or cyc=1 → cyc/stb low next cycle; one oh_en with status C; master_ready=1 afterwards.
- Macro on, TIMEOUT_CYCLES=8, ack never arrives → cyc low after 8 cycles; oh_en with status 0000001D.
